capture_merge_arbiter: RTL and testbench

- Packet-granular 2:1 arbiter that merges the forwarded stream (input 0) and the capture-copy stream (input 1) onto one AXI4-Stream master toward the output queues.
- Input 0 has priority.
- A starvation limit guarantees that input 1 is served.
- A grant is held for a whole packet, from first beat through tlast. Packets are never interleaved.

---
 rtl/capture_pkg.sv | 10 +
 rtl/capture_merge_arbiter_if.sv | 14 +
 rtl/pkt_counter.sv | 15 +
 rtl/capture_merge_arbiter.sv | 70 +++++++
 tb/tb_capture_merge_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and default starvation limit for the
// capture/forward merge arbiter.
package capture_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;
    localparam int STARVE_LIMIT_DEFAULT = 4;
endpackage

// File: rtl/capture_merge_arbiter_if.sv
// capture_merge_arbiter_if: one AXI4-Stream beat bundle with master/slave views.
interface capture_merge_arbiter_if #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
);
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                           tvalid;
    logic                           tready;
    logic                           tlast;
    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_counter.sv
// pkt_counter: 32-bit wrapping event counter with sync clear; only built
// when CAPTURE_MERGE_ARBITER_STATS_EN is defined.
`ifdef CAPTURE_MERGE_ARBITER_STATS_EN
module pkt_counter (
    input  logic        axi_aclk,
    input  logic        axi_reset,
    input  logic        en,
    output logic [31:0] cnt
);
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) cnt <= '0;
        else if (en) cnt <= cnt + 32'd1;
    end
endmodule
`endif

// File: rtl/capture_merge_arbiter.sv
// capture_merge_arbiter: packet-granular 2:1 AXI4-Stream merge, input 0 preferred,
// input 1 protected by a starvation limit; stats via CAPTURE_MERGE_ARBITER_STATS_EN.
module capture_merge_arbiter
    import capture_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    axi_aclk,
    input  logic                    axi_reset,
    input  logic                    arb_en,
    capture_merge_arbiter_if.slave  s_axis_0,
    capture_merge_arbiter_if.slave  s_axis_1,
    capture_merge_arbiter_if.master m_axis,
    output logic [31:0]             pkt_cnt_0,
    output logic [31:0]             pkt_cnt_1
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t state, state_nx;
    logic [7:0] starve_cnt, starve_nx;
    logic       sel1, done;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    assign sel1 = (state == GNT1);
    assign done = m_axis.tvalid && m_axis.tready && m_axis.tlast;

    // Grants are only decided in IDLE, which forces one bubble between packets.
    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        case (state)
            IDLE: if (arb_en) begin
                if (s_axis_1.tvalid && (!s_axis_0.tvalid || starve_cnt == LIMIT)) begin
                    state_nx  = GNT1;
                    starve_nx = '0;
                end else if (s_axis_0.tvalid) begin
                    state_nx  = GNT0;
                    starve_nx = !s_axis_1.tvalid ? 8'd0 : (starve_cnt < LIMIT) ? starve_cnt + 8'd1 : LIMIT;
                end
            end
            GNT0, GNT1: state_nx = done ? IDLE : state;
            default: state_nx = IDLE;
        endcase
    end

    assign m_axis.tdata    = sel1 ? s_axis_1.tdata : s_axis_0.tdata;
    assign m_axis.tstrb    = sel1 ? s_axis_1.tstrb : s_axis_0.tstrb;
    assign m_axis.tuser    = sel1 ? s_axis_1.tuser : s_axis_0.tuser;
    assign m_axis.tlast    = sel1 ? s_axis_1.tlast : s_axis_0.tlast;
    assign m_axis.tvalid   = (state == GNT0) ? s_axis_0.tvalid : sel1 ? s_axis_1.tvalid : 1'b0;
    assign s_axis_0.tready = (state == GNT0) && m_axis.tready;
    assign s_axis_1.tready = sel1 && m_axis.tready;

`ifdef CAPTURE_MERGE_ARBITER_STATS_EN
    pkt_counter u_cnt_0 (.axi_aclk(axi_aclk), .axi_reset(axi_reset), .en(done && !sel1), .cnt(pkt_cnt_0));
    pkt_counter u_cnt_1 (.axi_aclk(axi_aclk), .axi_reset(axi_reset), .en(done && sel1), .cnt(pkt_cnt_1));
`else
    assign pkt_cnt_0 = '0;
    assign pkt_cnt_1 = '0;
`endif
endmodule

// File: tb/tb_capture_merge_arbiter.sv
// tb_capture_merge_arbiter: directed bench for capture_merge_arbiter with a
// per-source packet generator and an in-order output checker.
module tb_capture_merge_arbiter;
    import capture_pkg::*;

`ifdef CAPTURE_MERGE_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, arb_en;
    logic [31:0] pkt_cnt_0, pkt_cnt_1;
    int          n_cmp = 0, n_bad = 0;
    int          left[2], len[2], pkt[2], beat[2], opkt[2], obeat[2];
    int          beats_out, cur, cyc;
    logic        mid, prev_last, rdy1_seen;
    int          out_src[$];
    logic [255:0] held;
    int          exp2[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int          exp6[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

    capture_merge_arbiter_if s0 ();
    capture_merge_arbiter_if s1 ();
    capture_merge_arbiter_if m ();

    always #5 clk = ~clk;

    capture_merge_arbiter dut (
        .axi_aclk (clk),
        .axi_reset(rst),
        .arb_en   (arb_en),
        .s_axis_0 (s0),
        .s_axis_1 (s1),
        .m_axis   (m),
        .pkt_cnt_0(pkt_cnt_0),
        .pkt_cnt_1(pkt_cnt_1)
    );

    function automatic logic [255:0] mk(int s, int p, int b);
        return (256'(s + 1) << 200) | 256'({8'(s), 16'(p), 16'(b)});
    endfunction

    function automatic logic [127:0] mku(int s, int p, int b);
        logic [255:0] d;
        d = mk(s, p, b);
        return {~d[63:0], d[63:0]};
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s0.tvalid = left[0] > 0;
        s0.tlast  = beat[0] == len[0] - 1;
        s0.tdata  = mk(0, pkt[0], beat[0]);
        s0.tuser  = mku(0, pkt[0], beat[0]);
        s0.tstrb  = 32'hFFFF_FFFF;
        s1.tvalid = left[1] > 0;
        s1.tlast  = beat[1] == len[1] - 1;
        s1.tdata  = mk(1, pkt[1], beat[1]);
        s1.tuser  = mku(1, pkt[1], beat[1]);
        s1.tstrb  = 32'h5555_5555;
    endtask

    task automatic resync();
        for (int i = 0; i < 2; i++) begin
            if (beat[i] != 0) begin
                beat[i] = 0;
                pkt[i]++;
            end
            opkt[i]  = pkt[i];
            obeat[i] = 0;
        end
        mid = 1'b0;
    endtask

    // One clock: sample/check away from the edge, then advance the sources.
    task automatic tick();
        logic hs0, hs1;
        int s;
        #1;
        hs0 = s0.tvalid && s0.tready;
        hs1 = s1.tvalid && s1.tready;
        chk("tready_excl", 256'(s0.tready && s1.tready), 256'(0));
        if (s1.tready) rdy1_seen = 1'b1;
        if (prev_last) chk("bubble", 256'(m.tvalid), 256'(0));
        prev_last = m.tvalid && m.tready && m.tlast;
        if (m.tvalid && m.tready) begin
            s = int'(m.tdata[32]);
            if (mid) chk("no_interleave", 256'(s), 256'(cur));
            chk("beat_data", m.tdata, mk(s, opkt[s], obeat[s]));
            chk("beat_user", 256'(m.tuser), 256'(mku(s, opkt[s], obeat[s])));
            chk("beat_strb", 256'(m.tstrb), s == 1 ? 256'(32'h5555_5555) : 256'(32'hFFFF_FFFF));
            chk("beat_last", 256'(m.tlast), 256'(obeat[s] == len[s] - 1));
            beats_out++;
            if (m.tlast) begin
                out_src.push_back(s);
                opkt[s]++;
                obeat[s] = 0;
                mid = 1'b0;
            end else begin
                obeat[s]++;
                mid = 1'b1;
                cur = s;
            end
        end
        @(posedge clk);
        #1;
        if (hs0) begin
            if (beat[0] == len[0] - 1) begin beat[0] = 0; pkt[0]++; left[0]--; end
            else beat[0]++;
        end
        if (hs1) begin
            if (beat[1] == len[1] - 1) begin beat[1] = 0; pkt[1]++; left[1]--; end
            else beat[1]++;
        end
        drive();
        @(negedge clk);
    endtask

    task automatic run(int target, int budget);
        cyc = 0;
        while (beats_out < target && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("run_timeout", 256'(beats_out >= target), 256'(1));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; len[i] = 1; pkt[i] = 0; beat[i] = 0; opkt[i] = 0; obeat[i] = 0;
        end
        beats_out = 0; cur = 0; mid = 1'b0; prev_last = 1'b0; rdy1_seen = 1'b0;
        rst = 1'b1; arb_en = 1'b1; m.tready = 1'b1;
        left[0] = 3; len[0] = 4;
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        // Reset state, with input 0 already presenting a beat.
        chk("rst_state", 256'(dut.state), 256'(IDLE));
        chk("rst_starve", 256'(dut.starve_cnt), 256'(0));
        chk("rst_m_tvalid", 256'(m.tvalid), 256'(0));
        chk("rst_tready_0", 256'(s0.tready), 256'(0));
        chk("rst_tready_1", 256'(s1.tready), 256'(0));
        chk("rst_pkt_cnt_0", 256'(pkt_cnt_0), 256'(0));
        chk("rst_pkt_cnt_1", 256'(pkt_cnt_1), 256'(0));
        tick();
        rst = 1'b0;

        // Input 0 alone: 3 x 4-beat packets, one bubble after each tlast.
        run(12, 40);
        chk("t1_cycles", 256'(cyc), 256'(15));
        chk("t1_pkts", 256'(out_src.size()), 256'(3));
        chk("t1_tready_1_never", 256'(rdy1_seen), 256'(0));
        chk("t1_pkt_cnt_0", 256'(pkt_cnt_0), STATS ? 256'(3) : 256'(0));

        // Both inputs continuously valid: starvation limit lets input 1 in every 5th packet.
        out_src.delete();
        beats_out = 0;
        len[0] = 2; len[1] = 2; left[0] = 8; left[1] = 2;
        drive();
        run(20, 80);
        chk("t2_cycles", 256'(cyc), 256'(30));
        chk("t2_seq_len", 256'(out_src.size()), 256'(10));
        for (int i = 0; i < 10 && i < out_src.size(); i++) chk("t2_seq", 256'(out_src[i]), 256'(exp2[i]));

        // Input 1 mid-packet with downstream stalls while input 0 becomes valid.
        out_src.delete();
        beats_out = 0;
        len[1] = 4; left[1] = 1;
        drive();
        tick();
        tick();
        left[0] = 1; len[0] = 2;
        drive();
        m.tready = 1'b0;
        held = m.tdata;
        chk("t3_stall_data", m.tdata, mk(1, pkt[1], 1));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_stall_valid", 256'(m.tvalid), 256'(1));
            chk("t3_stall_hold", m.tdata, held);
            chk("t3_stall_tready_0", 256'(s0.tready), 256'(0));
        end
        m.tready = 1'b1;
        run(6, 20);
        chk("t3_cycles", 256'(cyc), 256'(6));
        chk("t3_first_src", 256'(out_src.size() > 0 ? out_src[0] : -1), 256'(1));
        chk("t3_second_src", 256'(out_src.size() > 1 ? out_src[1] : -1), 256'(0));

        // arb_en dropped on beat 2 of a 5-beat packet.
        out_src.delete();
        beats_out = 0;
        left[0] = 2; len[0] = 5;
        drive();
        tick();
        tick();
        tick();
        arb_en = 1'b0;
        run(5, 20);
        chk("t4_finish_cycles", 256'(cyc), 256'(3));
        repeat (3) tick();
        chk("t4_hold_state", 256'(dut.state), 256'(IDLE));
        chk("t4_hold_m_tvalid", 256'(m.tvalid), 256'(0));
        chk("t4_pending_valid", 256'(s0.tvalid), 256'(1));
        chk("t4_hold_beats", 256'(beats_out), 256'(5));
        arb_en = 1'b1;
        run(10, 20);
        chk("t4_resume_cycles", 256'(cyc), 256'(6));

        // Reset asserted while beat 3 is on the bus.
        beats_out = 0;
        left[0] = 1; len[0] = 6; left[1] = 1; len[1] = 2;
        drive();
        tick();
        chk("t5_state_gnt0", 256'(dut.state), 256'(GNT0));
        chk("t5_starve_1", 256'(dut.starve_cnt), 256'(1));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_state", 256'(dut.state), 256'(IDLE));
        chk("t5_rst_m_tvalid", 256'(m.tvalid), 256'(0));
        chk("t5_rst_starve", 256'(dut.starve_cnt), 256'(0));
        chk("t5_rst_tready_0", 256'(s0.tready), 256'(0));
        chk("t5_rst_pkt_cnt_0", 256'(pkt_cnt_0), 256'(0));
        chk("t5_rst_pkt_cnt_1", 256'(pkt_cnt_1), 256'(0));
        left[0] = 0; left[1] = 0;
        resync();
        drive();
        tick();
        rst = 1'b0;
        tick();

        // 7 single-beat packets on input 0, 2 x 3-beat packets on input 1.
        out_src.delete();
        beats_out = 0;
        left[0] = 7; len[0] = 1; left[1] = 2; len[1] = 3;
        drive();
        run(13, 60);
        chk("t6_cycles", 256'(cyc), 256'(22));
        chk("t6_seq_len", 256'(out_src.size()), 256'(9));
        for (int i = 0; i < 9 && i < out_src.size(); i++) chk("t6_seq", 256'(out_src[i]), 256'(exp6[i]));
        chk("t6_pkt_cnt_0", 256'(pkt_cnt_0), STATS ? 256'(7) : 256'(0));
        chk("t6_pkt_cnt_1", 256'(pkt_cnt_1), STATS ? 256'(2) : 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
